// File: rtl/riscv_command_responder_if.sv
// Command/response handshake bundle between a command streamer (master)
// and the register-file responder (slave).
interface riscv_command_responder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/riscv_command_responder.sv
// Queued command responder: a FIFO feeds an IDLE/EXEC/RESP engine that
// performs WRITE/READ/ADD/NOP on a small 32-bit register file.
module riscv_command_responder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_REGS   = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  riscv_command_responder_if.slave    bus,
  output logic                        busy
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [4:0]       REG_LIM  = 5'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_ADD = 2'b11} op_e;

  typedef struct packed {
    op_e         op;
    logic [3:0]  addr;
    logic [31:0] data;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             fifo_q [FIFO_DEPTH];
  cmd_t             fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  cmd_t             ex_q, ex_d;
  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      regs_d [NUM_REGS];
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic push, pop, in_range;

  // cmd_ready looks only at the registered count, never at a same-cycle pop.
  assign bus.cmd_ready = (count_q != FULL_CNT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != IDLE) || (count_q != '0);

  assign push     = bus.cmd_valid && bus.cmd_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign in_range = {1'b0, ex_q.addr} < REG_LIM;

  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ex_d        = ex_q;
    regs_d      = regs_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{op: op_e'(bus.cmd_op), addr: bus.cmd_addr, data: bus.cmd_data};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      ex_d     = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pop) state_d = EXEC;
      end
      EXEC: begin
        rsp_data_d = '0;
        rsp_err_d  = (ex_q.op != OP_NOP) && !in_range;
        if (in_range) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ex_q.addr == 4'(i)) begin
              case (ex_q.op)
                OP_WRITE: begin
                  regs_d[i]  = ex_q.data;
                  rsp_data_d = ex_q.data;
                end
                OP_READ:  rsp_data_d = regs_q[i];
                OP_ADD: begin
                  regs_d[i]  = regs_q[i] + ex_q.data;
                  rsp_data_d = regs_d[i];
                end
                default: ;
              endcase
            end
          end
        end
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ex_q        <= '0;
      regs_q      <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ex_q        <= ex_d;
      regs_q      <= regs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_riscv_command_responder.sv
// Directed bench for riscv_command_responder: expected responses are queued
// at issue time and matched by an independent response monitor.
module tb_riscv_command_responder;
  logic clk = 1'b0;
  logic reset;
  logic busy;
  always #5 clk = ~clk;

  riscv_command_responder_if bus ();

  riscv_command_responder #(.FIFO_DEPTH(4), .NUM_REGS(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: a handshake visible at the falling edge completes on the next rising edge.
  initial begin
    logic [32:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data 0x%08h err %0b expected no response", bus.rsp_data, bus.rsp_err);
        end else begin
          exp = sbq.pop_front();
          check("rsp_data", bus.rsp_data, exp[31:0]);
          check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp[32]});
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_data, input logic exp_err);
    logic acc;
    sbq.push_back({exp_err, exp_data});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept for op %0d addr %0d", op, addr);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (sbq.size() != 0 || busy); n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", {31'b0, (sbq.size() == 0 && !busy)}, 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 4'd0;
    bus.cmd_data  = 32'd0;
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Write/read with latency: accept at edge t, rsp_valid first seen after t+2.
    send(2'b01, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("lat_t0", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_t1", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_t2", {31'b0, bus.rsp_valid}, 32'd1);
    @(posedge clk); #1;
    send(2'b10, 4'd3, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();

    // ADD wraps modulo 2^32.
    send(2'b01, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    send(2'b11, 4'd0, 32'h00000002, 32'h00000001, 1'b0);
    send(2'b10, 4'd0, 32'h0, 32'h00000001, 1'b0);
    drain();

    // Out-of-range addresses, last implemented register, NOP with a bad address.
    send(2'b01, 4'd13, 32'h12345678, 32'h0, 1'b1);
    send(2'b10, 4'd13, 32'h0, 32'h0, 1'b1);
    send(2'b10, 4'd11, 32'h0, 32'h0, 1'b0);
    send(2'b00, 4'd15, 32'hCAFEF00D, 32'h0, 1'b0);
    drain();

    // Backpressure: five commands in flight fill the engine plus FIFO.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(2'b01, 4'(i), 32'(i + 1), 32'(i + 1), 1'b0);
    end
    fork
      send(2'b01, 4'd5, 32'd6, 32'd6, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
          check("full_busy", {31'b0, busy}, 32'd1);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset while a response is pending and two commands are queued.
    bus.rsp_ready = 1'b0;
    send(2'b10, 4'd1, 32'h0, 32'd2, 1'b0);
    send(2'b10, 4'd2, 32'h0, 32'd3, 1'b0);
    send(2'b10, 4'd3, 32'h0, 32'd4, 1'b0);
    for (int n = 0; n < 20 && !bus.rsp_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("mid_rst_rsp_data", bus.rsp_data, 32'd0);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    send(2'b10, 4'd1, 32'h0, 32'd0, 1'b0);
    send(2'b10, 4'd5, 32'h0, 32'd0, 1'b0);
    send(2'b10, 4'd3, 32'h0, 32'd0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
